// File: rtl/dm_stream_pkg.sv
// Shared types and defaults for the data-memory block-read stream engine.
package dm_stream_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } entry_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO of {data, last} entries; push and pop in the same
// cycle are both honoured even when full.
module stream_fifo
    import dm_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 wr,
    output entry_t                 rd,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          store [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd      = store[rp];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wp] <= wr;
                wp        <= wp + PW'(1);
            end
            if (do_pop) begin
                rp <= rp + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_stream_reader.sv
// Sequential block reader on the data memory's second read port, delivering
// returned words as a valid/ready stream through a small FIFO.
module data_mem_stream_reader
    import dm_stream_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ADDR_W-1:0]           length,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_q,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output state_t                      fsm_state,
    output logic [$clog2(FIFO_DEPTH):0] fill_count
);

    // Stream handshake: a word transfers on a rising edge where out_valid and
    // out_ready are both high; while out_ready is low the head word is held.

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   remain;
    logic [READ_LAT-1:0] pipe_v;
    logic [READ_LAT-1:0] pipe_last;
    int                  inflight;
    logic                issue;
    logic                pop;
    logic                pop_last;
    logic                f_full;
    logic                f_empty;
    entry_t              push_e;
    entry_t              head;

    assign fsm_state = state;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight += int'(pipe_v[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so returned words never overflow.
    assign issue = (state == RUN) && (remain != '0) && !f_full &&
                   ((int'(fill_count) + inflight) < FIFO_DEPTH);

    assign out_valid = !f_empty;
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && head.last;
    assign out_data  = out_valid ? head.data : '0;
    assign out_last  = out_valid && head.last;
    assign push_e    = '{data: mem_q, last: pipe_last[READ_LAT-1]};

    stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pipe_v[READ_LAT-1]),
        .pop   (pop),
        .wr    (push_e),
        .rd    (head),
        .full  (f_full),
        .empty (f_empty),
        .count (fill_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_reg  <= '0;
            remain    <= '0;
            mem_addr  <= '0;
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            state     <= state_nx;
            pipe_v    <= READ_LAT'({pipe_v, issue});
            pipe_last <= READ_LAT'({pipe_last, issue && (remain == ADDR_W'(1))});
            if (state == IDLE && start) begin
                addr_reg <= base_addr;
                remain   <= length;
                if (length != '0) begin
                    mem_addr <= base_addr;
                end
            end else if (issue) begin
                addr_reg <= addr_reg + ADDR_W'(1);
                remain   <= remain - ADDR_W'(1);
                // After the final issue the address parks on the last word read.
                if (remain != ADDR_W'(1)) begin
                    mem_addr <= addr_reg + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (length != '0) ? RUN : FINISH;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && remain == ADDR_W'(1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop_last && inflight == 0) begin
                    state_nx = FINISH;
                end
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_stream_reader.sv
// Scoreboard bench for data_mem_stream_reader with a behavioural 1-cycle memory.
module tb_data_mem_stream_reader;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic [1:0]        fsm_state;
    logic [2:0]        fill_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int e0 = 0;
    int popped = 0;
    int fill_max = 0;
    int ready_mode = 0;
    int pcnt = 0;
    logic [3:0] pat = 4'b1001;

    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    bit                log_on = 0;
    bit                stall_prev = 0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;

    data_mem_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_q      (mem_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .fsm_state  (fsm_state),
        .fill_count (fill_count)
    );

    // clock / reset
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) + DATA_W'(24'h100);
    endfunction

    always @(posedge clk) mem_q <= mem_val(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic start_xfer(input int base, input int len);
        base_addr = ADDR_W'(base);
        length    = ADDR_W'(len);
        start     = 1'b1;
        for (int i = 0; i < len; i++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(base + i);
            exp_q.push_back({mem_val(a), (i == len - 1)});
        end
        tick();
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input string tag, input bit check_lat, input int exp_cycles);
        int c;
        c = 0;
        while (!done && c < 300) begin
            tick();
            c++;
        end
        if (!done) begin
            check({tag, "_timeout"}, done, 1);
        end else begin
            if (check_lat) check({tag, "_latency"}, cyc - e0, exp_cycles);
            check({tag, "_busy_at_done"}, busy, 0);
            tick();
            check({tag, "_done_pulse"}, done, 0);
        end
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    // out_ready pattern driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    out_ready = pat[pcnt % 4];
                    pcnt++;
                end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 0;
        end else begin
            if (int'(fill_count) > fill_max) fill_max = int'(fill_count);
            if (log_on && busy && (addr_log.size() == 0 || addr_log[$] != mem_addr))
                addr_log.push_back(mem_addr);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_valid, 0);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_q.pop_front();
                    check("data", out_data, e[DATA_W:1]);
                    check("last", out_last, e[0]);
                end
                popped++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] held;
        rst = 0; start = 0; base_addr = '0; length = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_count", fill_count, 0);
        tick();
        rst = 1;
        tick();

        // basic transfer with ready held high
        start_xfer(40, 4);
        check("t1_addr0", mem_addr, 40);
        check("t1_busy", busy, 1);
        check("t1_valid_e0", out_valid, 0);
        tick();
        check("t1_valid_e1", out_valid, 0);
        tick();
        check("t1_valid_e2", out_valid, 1);
        check("t1_first", out_data, 24'h128);
        wait_done("t1", 1, 6);

        // same transfer with 1,0,0,1 backpressure
        ready_mode = 1; pcnt = 0;
        tick();
        start_xfer(40, 4);
        wait_done("t2", 0, 0);
        ready_mode = 0;

        // address wrap
        tick();
        addr_log.delete();
        log_on = 1;
        start_xfer(19'h7FFFE, 3);
        wait_done("t3", 1, 5);
        log_on = 0;
        check("t3_addr_n", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("t3_addr0", addr_log[0], 19'h7FFFE);
            check("t3_addr1", addr_log[1], 19'h7FFFF);
            check("t3_addr2", addr_log[2], 19'h00000);
        end

        // zero length
        tick();
        held = mem_addr;
        start_xfer(19'h55, 0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_addr", mem_addr, held);
        check("t4_valid", out_valid, 0);
        tick();
        check("t4_done_pulse", done, 0);
        check("t4_valid2", out_valid, 0);

        // reset mid-transfer
        tick();
        popped = 0;
        start_xfer(100, 6);
        begin
            int c;
            c = 0;
            while (popped < 2 && c < 50) begin
                tick();
                c++;
            end
            check("t5_two_popped", popped, 2);
        end
        tick();
        #3;
        rst = 0;
        #1;
        exp_q.delete();
        check("t5_busy", busy, 0);
        check("t5_valid", out_valid, 0);
        check("t5_done", done, 0);
        check("t5_state", fsm_state, 0);
        check("t5_addr", mem_addr, 0);
        tick();
        rst = 1;
        tick();
        start_xfer(0, 2);
        wait_done("t5b", 1, 4);

        // start while busy is ignored
        tick();
        start_xfer(200, 5);
        tick();
        tick();
        base_addr = 19'd500; length = 19'd3; start = 1;
        tick();
        start = 0;
        wait_done("t6", 1, 7);
        check("t6_idle", fsm_state, 0);

        // random base, random backpressure
        ready_mode = 2;
        tick();
        start_xfer(int'($urandom_range(0, 19'h7FFFF)), int'($urandom_range(5, 12)));
        wait_done("t7", 0, 0);
        ready_mode = 0;

        check("fill_max_le_depth", (fill_max <= 4), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
